// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier and restoring divider.
// One result bit per cycle; signed operands are handled as magnitudes plus a sign fix.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;

  logic                 accept;
  logic                 is_div;
  logic                 sgn;
  logic                 zero_div;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       shl;
  logic                 ge;
  logic [WIDTH-1:0]     rdiff;
  logic [WIDTH-1:0]     rem_n;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   prod_neg;

  always_comb begin
    accept   = start && (state_q == IDLE || state_q == DONE);
    is_div   = op_q[1];
    sgn      = ~op_q[0];
    zero_div = is_div && (b_q == '0);
    mag_a    = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b    = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, m_q} : '0);
    // Remainder shifted left with the next dividend bit.
    shl      = acc_q[2*WIDTH-1:WIDTH-1];
    ge       = shl >= {1'b0, m_q};
    rdiff    = shl[WIDTH-1:0] - m_q;
    rem_n    = ge ? rdiff : shl[WIDTH-1:0];
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    prod_neg = -acc_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    if (accept) begin
      state_d = PREP;
      op_d    = op;
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      dz_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        PREP: begin
          negq_d = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          negr_d = sgn & a_q[WIDTH-1];
          if (zero_div) begin
            // Divide-by-zero spends one extra PREP cycle, then reports.
            if (cnt_q == '0) begin
              cnt_d = {{(CW-1){1'b0}}, 1'b1};
            end else begin
              cnt_d   = '0;
              dz_d    = 1'b1;
              state_d = DONE;
            end
          end else begin
            m_d     = is_div ? mag_b : mag_a;
            acc_d   = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            acc_d = {rem_n, acc_q[WIDTH-2:0], ge};
          end else begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            lo_d = negq_q ? -quo : quo;
            hi_d = negr_q ? -rem : rem;
          end else begin
            {hi_d, lo_d} = negq_q ? prod_neg : acc_q;
          end
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == PREP) || (state_q == RUN)
                     || (state_q == FIX);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops
// checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model(
    input logic [1:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx;
    longint sy;
    longint unsigned ux;
    longint unsigned uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return 64'(ux * uy);
      2'd2: return {32'(sx % sy), 32'(sx / sy)};
      default: return {32'(ux % uy), 32'(ux / uy)};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  int          hold,
    output int          l,
    output int          bn,
    output logic        d0
  );
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (hold == 0) start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
    d0 = div_by_zero;
    l = 0;
    bn = busy ? 1 : 0;
    while (!done && l < 200) begin
      @(posedge clock);
      @(negedge clock);
      l++;
      if (hold > 0 && l >= hold) start = 1'b0;
      if (busy) bn++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    start = 1'b1;
    op = 2'd0;
    a = 32'd3;
    b = 32'd5;
    repeat (3) @(negedge clock);
    total++;
    if ({hi, lo} !== 64'd0) begin
      $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
      bad++;
    end
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      $display("FAIL reset_flags got=%b exp=000",
               {busy, done, div_by_zero});
      bad++;
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    int l, bn;
    logic d0;
    do_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, l, bn, d0);
    total++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      $display("FAIL mult_res got=%h exp=FFFFFFFFFFFFFFEB",
               {hi, lo});
      bad++;
    end
    total++;
    if (l !== 34) begin
      $display("FAIL mult_lat got=%0d exp=34", l);
      bad++;
    end
    total++;
    if (bn !== 34) begin
      $display("FAIL mult_busy got=%0d exp=34", bn);
      bad++;
    end
    @(negedge clock);
    total++;
    if (done !== 1'b0) begin
      $display("FAIL mult_done_pulse got=%b exp=0", done);
      bad++;
    end
  endtask

  task automatic test_multu_hold();
    int l, bn, extra;
    logic d0;
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 25, l, bn, d0);
    total++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      $display("FAIL multu_res got=%h exp=FFFFFFFE00000001",
               {hi, lo});
      bad++;
    end
    total++;
    if (l !== 34) begin
      $display("FAIL multu_lat got=%0d exp=34", l);
      bad++;
    end
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) extra++;
    end
    total++;
    if (extra !== 0) begin
      $display("FAIL multu_extra_done got=%0d exp=0", extra);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    int l, bn;
    logic d0;
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, l, bn, d0);
    total++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      $display("FAIL div_res got=%h exp=FFFFFFFFFFFFFFFD",
               {hi, lo});
      bad++;
    end
    do_op(2'd3, 32'd100, 32'd7, 0, l, bn, d0);
    total++;
    if (l !== 34) begin
      $display("FAIL b2b_lat got=%0d exp=34", l);
      bad++;
    end
    total++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      $display("FAIL b2b_res got=%h exp=%h", {hi, lo},
               {32'd2, 32'd14});
      bad++;
    end
  endtask

  task automatic test_div_by_zero();
    int l, bn;
    logic d0;
    do_op(2'd3, 32'h0ACF1234, 32'h2000, 0, l, bn, d0);
    total++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      $display("FAIL dz_prior got=%h exp=%h", {hi, lo},
               {32'h1234, 32'h5678});
      bad++;
    end
    do_op(2'd3, 32'd5, 32'd0, 0, l, bn, d0);
    total++;
    if (l !== 2) begin
      $display("FAIL dz_lat got=%0d exp=2", l);
      bad++;
    end
    total++;
    if (div_by_zero !== 1'b1) begin
      $display("FAIL dz_flag got=%b exp=1", div_by_zero);
      bad++;
    end
    total++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      $display("FAIL dz_hold got=%h exp=%h", {hi, lo},
               {32'h1234, 32'h5678});
      bad++;
    end
    repeat (5) @(negedge clock);
    total++;
    if (div_by_zero !== 1'b1) begin
      $display("FAIL dz_sticky got=%b exp=1", div_by_zero);
      bad++;
    end
    do_op(2'd0, 32'd2, 32'd3, 0, l, bn, d0);
    total++;
    if (d0 !== 1'b0) begin
      $display("FAIL dz_clear got=%b exp=0", d0);
      bad++;
    end
    total++;
    if ({hi, lo} !== 64'd6) begin
      $display("FAIL dz_next got=%h exp=6", {hi, lo});
      bad++;
    end
  endtask

  task automatic test_div_overflow();
    int l, bn;
    logic d0;
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, l, bn, d0);
    total++;
    if ({hi, lo} !== 64'h00000000_80000000) begin
      $display("FAIL ovf_res got=%h exp=0000000080000000",
               {hi, lo});
      bad++;
    end
    total++;
    if (div_by_zero !== 1'b0) begin
      $display("FAIL ovf_flag got=%b exp=0", div_by_zero);
      bad++;
    end
  endtask

  task automatic test_reset_mid_op();
    int l, bn, dn;
    logic d0;
    op = 2'd0;
    a = 32'd123456;
    b = 32'd789;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
    end
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL rst_pre_busy got=%b exp=1", busy);
      bad++;
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      $display("FAIL rst_async got=%h/%h/%b/%b exp=0",
               hi, lo, busy, done);
      bad++;
    end
    start = 1'b1;
    dn = 0;
    repeat (4) begin
      @(negedge clock);
      if (done || busy) dn++;
    end
    total++;
    if (dn !== 0) begin
      $display("FAIL rst_quiet got=%0d exp=0", dn);
      bad++;
    end
    start = 1'b0;
    reset = 1'b1;
    do_op(2'd0, 32'd6, 32'd7, 0, l, bn, d0);
    total++;
    if ({hi, lo} !== 64'd42 || l !== 34) begin
      $display("FAIL rst_after got=%h lat=%0d exp=42 lat=34",
               {hi, lo}, l);
      bad++;
    end
  endtask

  task automatic test_random();
    int l, bn;
    logic d0;
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    logic [63:0] prev;
    prev = 64'd42;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(o, x, y, 0, l, bn, d0);
      if (o[1] && y == 32'd0) begin
        total++;
        if (l !== 2 || div_by_zero !== 1'b1
            || {hi, lo} !== prev) begin
          $display("FAIL rnd_dz%0d got=%h dz=%b lat=%0d exp=%h",
                   i, {hi, lo}, div_by_zero, l, prev);
          bad++;
        end
      end else begin
        e = model(o, x, y);
        total++;
        if ({hi, lo} !== e || div_by_zero !== 1'b0
            || l !== 34) begin
          $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h exp=%h",
                   i, o, x, y, {hi, lo}, e);
          bad++;
        end
        prev = e;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_hold();
    test_back_to_back();
    test_div_by_zero();
    test_div_overflow();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
